md4: RTL and testbench
======================

Name: md4

Overview:
- Streaming MD4 (RFC 1320) hash core.
- Pulls a message of INPUT_SIZE_IN bytes from an upstream first-word-fall-through byte FIFO.
- Performs all padding and length appending internally.
- Pushes the 16-byte digest into a downstream byte FIFO.
- Sits between a data-source FIFO and a result FIFO under a simple START/BUSY/DONE control handshake.

Parameters:
- none (block size 64 B, digest 16 B, length field 64 bit are fixed by MD4)

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RESET  in  1  asynchronous, active-high reset
- START_IN  in  1  level request to hash one message
- BUSY_OUT  out  1  high from accepted start until DONE state
- DONE_OUT  out  1  high in DONE state
- INPUT_SIZE_IN  in  64  message length in bytes, sampled at start
- INPUT_BYTE  in  8  current head byte of input FIFO (FWFT: valid before read)
- INPUT_EMPTY  in  1  active-low empty flag: 1 = byte available
- INPUT_READ  out  1  one-cycle pop; INPUT_BYTE is consumed in the same cycle
- OUTPUT_BYTE  out  8  digest byte, valid while OUTPUT_WRITE=1
- OUTPUT_FULL  in  1  active-low full flag: 1 = room available
- OUTPUT_WRITE  out  1  one-cycle push of OUTPUT_BYTE

Behaviour:
- Reset: state IDLE; BUSY_OUT=0, DONE_OUT=0, INPUT_READ=0, OUTPUT_WRITE=0, OUTPUT_BYTE=0; chaining registers A..D=67452301/efcdab89/98badcfe/10325476; counters cleared. Reset mid-operation aborts immediately to these values.
- IDLE:
  - When START_IN=1: latch INPUT_SIZE_IN, load the IV, clear the byte counter, go to LOAD, set BUSY_OUT=1.
- LOAD: fills the 64-byte block buffer, one byte per cycle.
  - While message bytes remain and INPUT_EMPTY=1: assert INPUT_READ, store INPUT_BYTE, increment the byte counter. Consecutive-cycle reads are legal. If INPUT_EMPTY=0, stall without reading.
  - After the last message byte: write 0x80, then 0x00 bytes. No FIFO reads.
  - Block positions 56..63 of the final block carry the bit length (size*8 mod 2^64), little-endian.
  - If (size mod 64) ≥ 56, the padding spills into an extra block.
  - The core never reads more than INPUT_SIZE_IN bytes; size 0 means no reads.
- ROUND: 48 steps, one per cycle.
  - Words X[k] are little-endian from the buffer.
  - Round 1: F=(x&y)|(~x&z), no constant.
  - Round 2: G=(x&y)|(x&z)|(y&z), constant 5a827999.
  - Round 3: H=x^y^z, constant 6ed9eba1.
  - Standard RFC 1320 word order and shifts {3,7,11,19}, {3,5,9,13}, {3,9,11,15}.
  - All adds mod 2^32.
- UPDATE: A..D += working a..d (mod 2^32). Then go to LOAD if more blocks remain, else OUTPUT.
- OUTPUT:
  - Emits digest bytes A[7:0], A[15:8] … D[31:24] (16 bytes, standard hex order).
  - One byte per cycle, only when OUTPUT_FULL=1; otherwise hold and stall.
- DONE:
  - BUSY_OUT=0, DONE_OUT=1.
  - Remain in DONE until START_IN=0, then return to IDLE.
  - START_IN held high does not retrigger a hash.
- START_IN changes while BUSY are ignored; INPUT_SIZE_IN is sampled only in IDLE.
- Latency with no stalls: about 64+48+1 cycles per block plus 16 output cycles. A one-block message must finish well under 2000 cycles.

Decomposition:
- Package md4_pkg holds:
  - IV constants
  - round constants 5a827999 and 6ed9eba1
  - shift tables
  - message-word index tables for rounds 2 and 3
  - FSM state enum (IDLE, LOAD, ROUND, UPDATE, OUTPUT, DONE)
  - F/G/H functions
- One natural sub-module: md4_step (combinational single-step datapath: function select, add, rotate).
- FSM, buffer and I/O stay in md4.

Test Plan:
- Size 16, bytes "1234567891234567" (0x31..0x37), EMPTY=1, FULL=1, START held until DONE → exactly 16 reads; output bytes 2b aa 06 45 e8 c3 3c 14 02 27 16 e6 da 14 b8 1c; DONE_OUT rises.
- Size 0 → no INPUT_READ; digest 31d6cfe0d16ae931b73c59d7e0c089c0.
- Size 3 "abc" → a448017aaf21d8525fc10ae87aa6729d; size 1 "a" → bde52cb31de33e46245e05fbdbd6fb24.
- Size 62 "A–Z a–z 0–9" (two-block padding) → 043f8582f241db351ce627e153e7f0e4; size 80 "1234567890"×8 → e33b4ddc9c38f2199c3e7b164fcc0536.
- Backpressure: toggle INPUT_EMPTY and OUTPUT_FULL randomly during the 16-byte case → no read while EMPTY=0, no write while FULL=0, same digest.
- Assert RESET mid-ROUND, then restart with "abc" → all outputs return to reset values and the correct digest follows; START held high after DONE produces no second hash.

Source files
------------

// File: rtl/md4_pkg.sv
// MD4 constants, step tables, boolean functions and controller states.
package md4_pkg;

    localparam logic [31:0] IV_A = 32'h67452301;
    localparam logic [31:0] IV_B = 32'hefcdab89;
    localparam logic [31:0] IV_C = 32'h98badcfe;
    localparam logic [31:0] IV_D = 32'h10325476;

    localparam logic [31:0] K_R2 = 32'h5a827999;
    localparam logic [31:0] K_R3 = 32'h6ed9eba1;

    localparam logic [3:0] R2_IDX [16] = '{4'd0, 4'd4, 4'd8, 4'd12, 4'd1, 4'd5, 4'd9, 4'd13,
                                            4'd2, 4'd6, 4'd10, 4'd14, 4'd3, 4'd7, 4'd11, 4'd15};
    localparam logic [3:0] R3_IDX [16] = '{4'd0, 4'd8, 4'd4, 4'd12, 4'd2, 4'd10, 4'd6, 4'd14,
                                            4'd1, 4'd9, 4'd5, 4'd13, 4'd3, 4'd11, 4'd7, 4'd15};

    localparam logic [4:0] S_R1 [4] = '{5'd3, 5'd7, 5'd11, 5'd19};
    localparam logic [4:0] S_R2 [4] = '{5'd3, 5'd5, 5'd9, 5'd13};
    localparam logic [4:0] S_R3 [4] = '{5'd3, 5'd9, 5'd11, 5'd15};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROUND,
        ST_UPDATE,
        ST_OUTPUT,
        ST_DONE
    } state_t;

    function automatic logic [31:0] md4_f(input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] z);
        md4_f = (x & y) | (~x & z);
    endfunction

    function automatic logic [31:0] md4_g(input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] z);
        md4_g = (x & y) | (x & z) | (y & z);
    endfunction

    function automatic logic [31:0] md4_h(input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] z);
        md4_h = x ^ y ^ z;
    endfunction

    // Message word used by step 0..47.
    function automatic logic [3:0] msg_index(input logic [5:0] step);
        case (step[5:4])
            2'd0:    msg_index = step[3:0];
            2'd1:    msg_index = R2_IDX[step[3:0]];
            default: msg_index = R3_IDX[step[3:0]];
        endcase
    endfunction

    // Left-rotate amount for step 0..47.
    function automatic logic [4:0] shift_amt(input logic [5:0] step);
        case (step[5:4])
            2'd0:    shift_amt = S_R1[step[1:0]];
            2'd1:    shift_amt = S_R2[step[1:0]];
            default: shift_amt = S_R3[step[1:0]];
        endcase
    endfunction

    function automatic logic [31:0] rotl32(input logic [31:0] v, input logic [4:0] s);
        logic [63:0] t;
        t = {v, v} << s;
        rotl32 = t[63:32];
    endfunction

endpackage

// File: rtl/md4_step.sv
// One MD4 step: new word = (a + fn(b,c,d) + x + k) <<< s.
module md4_step
    import md4_pkg::*;
(
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic [31:0] c_in,
    input  logic [31:0] d_in,
    input  logic [31:0] x_in,
    input  logic [5:0]  step_in,
    output logic [31:0] a_out
);

    logic [31:0] f_val;
    logic [31:0] k_val;
    logic [31:0] sum;

    // Round-dependent function and constant, then add and rotate.
    always_comb begin
        f_val = '0;
        k_val = '0;
        case (step_in[5:4])
            2'd0: begin
                f_val = md4_f(b_in, c_in, d_in);
                k_val = '0;
            end
            2'd1: begin
                f_val = md4_g(b_in, c_in, d_in);
                k_val = K_R2;
            end
            default: begin
                f_val = md4_h(b_in, c_in, d_in);
                k_val = K_R3;
            end
        endcase
        sum   = a_in + f_val + x_in + k_val;
        a_out = rotl32(sum, shift_amt(step_in));
    end

endmodule

// File: rtl/md4.sv
// Streaming MD4 core: FIFO in, internal padding, 16-byte digest FIFO out.
module md4
    import md4_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START_IN,
    output logic        BUSY_OUT,
    output logic        DONE_OUT,
    input  logic [63:0] INPUT_SIZE_IN,
    input  logic [7:0]  INPUT_BYTE,
    input  logic        INPUT_EMPTY,
    output logic        INPUT_READ,
    output logic [7:0]  OUTPUT_BYTE,
    input  logic        OUTPUT_FULL,
    output logic        OUTPUT_WRITE
);

    state_t      state_q, state_d;
    logic [63:0] size_q, size_d;
    logic [63:0] last_blk_q, last_blk_d;
    logic [63:0] blk_q, blk_d;
    logic [63:0] msg_cnt_q, msg_cnt_d;
    logic [5:0]  pos_q, pos_d;
    logic        pad_q, pad_d;
    logic [5:0]  step_q, step_d;
    logic [3:0]  out_idx_q, out_idx_d;
    logic [31:0] ha_q, hb_q, hc_q, hd_q, ha_d, hb_d, hc_d, hd_d;
    logic [31:0] wa_q, wb_q, wc_q, wd_q, wa_d, wb_d, wc_d, wd_d;

    logic [7:0]  block_q [64];
    logic        buf_we;
    logic [7:0]  buf_wdata;
    logic        load_adv;
    logic [63:0] len_bits;
    logic [3:0]  x_idx;
    logic [31:0] x_word;
    logic [31:0] step_out;
    logic [31:0] digest_word;

    assign len_bits = size_q << 3;
    assign x_idx    = msg_index(step_q);
    assign x_word   = {block_q[{x_idx, 2'd3}], block_q[{x_idx, 2'd2}],
                       block_q[{x_idx, 2'd1}], block_q[{x_idx, 2'd0}]};

    md4_step u_step (
        .a_in    (wa_q),
        .b_in    (wb_q),
        .c_in    (wc_q),
        .d_in    (wd_q),
        .x_in    (x_word),
        .step_in (step_q),
        .a_out   (step_out)
    );

    // Block buffer write port; contents are don't-care until filled.
    always_ff @(posedge CLK) begin
        if (buf_we) begin
            block_q[pos_q] <= buf_wdata;
        end
    end

    // State and datapath registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            size_q     <= '0;
            last_blk_q <= '0;
            blk_q      <= '0;
            msg_cnt_q  <= '0;
            pos_q      <= '0;
            pad_q      <= 1'b0;
            step_q     <= '0;
            out_idx_q  <= '0;
            ha_q       <= IV_A;
            hb_q       <= IV_B;
            hc_q       <= IV_C;
            hd_q       <= IV_D;
            wa_q       <= '0;
            wb_q       <= '0;
            wc_q       <= '0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            last_blk_q <= last_blk_d;
            blk_q      <= blk_d;
            msg_cnt_q  <= msg_cnt_d;
            pos_q      <= pos_d;
            pad_q      <= pad_d;
            step_q     <= step_d;
            out_idx_q  <= out_idx_d;
            ha_q       <= ha_d;
            hb_q       <= hb_d;
            hc_q       <= hc_d;
            hd_q       <= hd_d;
            wa_q       <= wa_d;
            wb_q       <= wb_d;
            wc_q       <= wc_d;
            wd_q       <= wd_d;
        end
    end

    // Next-state, buffer fill, round sequencing and I/O handshakes.
    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        last_blk_d  = last_blk_q;
        blk_d       = blk_q;
        msg_cnt_d   = msg_cnt_q;
        pos_d       = pos_q;
        pad_d       = pad_q;
        step_d      = step_q;
        out_idx_d   = out_idx_q;
        ha_d        = ha_q;
        hb_d        = hb_q;
        hc_d        = hc_q;
        hd_d        = hd_q;
        wa_d        = wa_q;
        wb_d        = wb_q;
        wc_d        = wc_q;
        wd_d        = wd_q;
        buf_we      = 1'b0;
        buf_wdata   = '0;
        load_adv    = 1'b0;
        digest_word = '0;
        INPUT_READ   = 1'b0;
        OUTPUT_WRITE = 1'b0;
        OUTPUT_BYTE  = '0;
        BUSY_OUT     = 1'b0;
        DONE_OUT     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START_IN) begin
                    size_d = INPUT_SIZE_IN;
                    // Index of the block holding the length field.
                    last_blk_d = (INPUT_SIZE_IN + 64'd8) >> 6;
                    blk_d      = '0;
                    msg_cnt_d  = '0;
                    pos_d      = '0;
                    pad_d      = 1'b0;
                    ha_d       = IV_A;
                    hb_d       = IV_B;
                    hc_d       = IV_C;
                    hd_d       = IV_D;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                BUSY_OUT = 1'b1;
                // Sizing of last_blk guarantees message and 0x80 end before 56 in the last block.
                if (blk_q == last_blk_q && pos_q >= 6'd56) begin
                    buf_wdata = len_bits[{pos_q[2:0], 3'b000} +: 8];
                    load_adv  = 1'b1;
                end else if (msg_cnt_q != size_q) begin
                    if (INPUT_EMPTY) begin
                        INPUT_READ = 1'b1;
                        buf_wdata  = INPUT_BYTE;
                        msg_cnt_d  = msg_cnt_q + 64'd1;
                        load_adv   = 1'b1;
                    end
                end else if (!pad_q) begin
                    buf_wdata = 8'h80;
                    pad_d     = 1'b1;
                    load_adv  = 1'b1;
                end else begin
                    load_adv = 1'b1;
                end
                if (load_adv) begin
                    buf_we = 1'b1;
                    pos_d  = pos_q + 6'd1;
                    if (pos_q == 6'd63) begin
                        state_d = ST_ROUND;
                        step_d  = '0;
                        wa_d    = ha_q;
                        wb_d    = hb_q;
                        wc_d    = hc_q;
                        wd_d    = hd_q;
                    end
                end
            end
            ST_ROUND: begin
                BUSY_OUT = 1'b1;
                // Rotating the working registers each step replaces the abcd/dabc/cdab/bcda operand order.
                wa_d   = wd_q;
                wb_d   = step_out;
                wc_d   = wb_q;
                wd_d   = wc_q;
                step_d = step_q + 6'd1;
                if (step_q == 6'd47) begin
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                BUSY_OUT = 1'b1;
                ha_d  = ha_q + wa_q;
                hb_d  = hb_q + wb_q;
                hc_d  = hc_q + wc_q;
                hd_d  = hd_q + wd_q;
                blk_d = blk_q + 64'd1;
                if (blk_q == last_blk_q) begin
                    state_d   = ST_OUTPUT;
                    out_idx_d = '0;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_OUTPUT: begin
                BUSY_OUT = 1'b1;
                case (out_idx_q[3:2])
                    2'd0:    digest_word = ha_q;
                    2'd1:    digest_word = hb_q;
                    2'd2:    digest_word = hc_q;
                    default: digest_word = hd_q;
                endcase
                if (OUTPUT_FULL) begin
                    OUTPUT_WRITE = 1'b1;
                    OUTPUT_BYTE  = digest_word[{out_idx_q[1:0], 3'b000} +: 8];
                    out_idx_d    = out_idx_q + 4'd1;
                    if (out_idx_q == 4'd15) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                DONE_OUT = 1'b1;
                if (!START_IN) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_md4.sv
// Bench for md4: FIFO models, digest scoreboard, known-answer and control scenarios.
module tb_md4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START_IN = 1'b0;
    logic        BUSY_OUT;
    logic        DONE_OUT;
    logic [63:0] INPUT_SIZE_IN = '0;
    logic [7:0]  INPUT_BYTE = '0;
    logic        INPUT_EMPTY = 1'b0;
    logic        INPUT_READ;
    logic [7:0]  OUTPUT_BYTE;
    logic        OUTPUT_FULL = 1'b1;
    logic        OUTPUT_WRITE;

    md4 dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .START_IN      (START_IN),
        .BUSY_OUT      (BUSY_OUT),
        .DONE_OUT      (DONE_OUT),
        .INPUT_SIZE_IN (INPUT_SIZE_IN),
        .INPUT_BYTE    (INPUT_BYTE),
        .INPUT_EMPTY   (INPUT_EMPTY),
        .INPUT_READ    (INPUT_READ),
        .OUTPUT_BYTE   (OUTPUT_BYTE),
        .OUTPUT_FULL   (OUTPUT_FULL),
        .OUTPUT_WRITE  (OUTPUT_WRITE)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    bit bp_mode = 1'b0;
    logic [7:0] in_q [$];
    logic [7:0] exp_q [$];

    // FIFO models and output scoreboard: sample at negedge, apply effects just after posedge.
    initial begin : monitor
        logic       s_rd, s_wr, s_em, s_fu;
        logic [7:0] s_ob, exp_b, junk;
        forever begin
            @(negedge CLK);
            s_rd = INPUT_READ;
            s_wr = OUTPUT_WRITE;
            s_em = INPUT_EMPTY;
            s_fu = OUTPUT_FULL;
            s_ob = OUTPUT_BYTE;
            if (s_rd) begin
                rd_cnt++;
                total++;
                if (s_em !== 1'b1) begin
                    bad++;
                    $display("FAIL read_when_empty: INPUT_READ=1 with INPUT_EMPTY=%0b, required EMPTY=1", s_em);
                end
            end
            if (s_wr) begin
                wr_cnt++;
                total++;
                if (s_fu !== 1'b1) begin
                    bad++;
                    $display("FAIL write_when_full: OUTPUT_WRITE=1 with OUTPUT_FULL=%0b, required FULL=1", s_fu);
                end
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL digest_byte: got %02h, no byte expected", s_ob);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (s_ob !== exp_b) begin
                        bad++;
                        $display("FAIL digest_byte: got %02h expected %02h", s_ob, exp_b);
                    end
                end
            end
            @(posedge CLK);
            #1;
            if (s_rd && in_q.size() > 0) junk = in_q.pop_front();
            INPUT_BYTE  = (in_q.size() > 0) ? in_q[0] : 8'h00;
            INPUT_EMPTY = (in_q.size() > 0) && (!bp_mode || ($urandom_range(0, 1) == 1));
            OUTPUT_FULL = !bp_mode || ($urandom_range(0, 1) == 1);
        end
    end

    // Queue the digest and a guard byte past the message end, start, and wait for DONE.
    task automatic do_hash(input logic [63:0] size, input logic [127:0] dig, output bit done_ok);
        for (int i = 0; i < 16; i++) exp_q.push_back(dig[127 - 8 * i -: 8]);
        in_q.push_back(8'hEE);
        rd_cnt = 0;
        wr_cnt = 0;
        @(posedge CLK);
        #1;
        INPUT_SIZE_IN = size;
        START_IN = 1'b1;
        done_ok = 1'b0;
        for (int c = 0; c < 4000 && !done_ok; c++) begin
            @(negedge CLK);
            if (DONE_OUT === 1'b1) done_ok = 1'b1;
        end
    endtask

    task automatic release_start();
        @(posedge CLK);
        #1;
        START_IN = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        in_q.delete();
        exp_q.delete();
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) in_q.push_back(s[i]);
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        total++;
        if ({BUSY_OUT, DONE_OUT, INPUT_READ, OUTPUT_WRITE, OUTPUT_BYTE} !== 12'h000) begin
            bad++;
            $display("FAIL reset_outputs: busy=%0b done=%0b rd=%0b wr=%0b byte=%02h, required all 0",
                     BUSY_OUT, DONE_OUT, INPUT_READ, OUTPUT_WRITE, OUTPUT_BYTE);
        end
        @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    task automatic test_known_answers();
        string        vmsg [6];
        logic [127:0] vdig [6];
        bit           ok;
        vmsg[0] = "";
        vdig[0] = 128'h31d6cfe0d16ae931b73c59d7e0c089c0;
        vmsg[1] = "a";
        vdig[1] = 128'hbde52cb31de33e46245e05fbdbd6fb24;
        vmsg[2] = "abc";
        vdig[2] = 128'ha448017aaf21d8525fc10ae87aa6729d;
        vmsg[3] = "1234567891234567";
        vdig[3] = 128'h2baa0645e8c33c14022716e6da14b81c;
        vmsg[4] = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789";
        vdig[4] = 128'h043f8582f241db351ce627e153e7f0e4;
        vmsg[5] = "12345678901234567890123456789012345678901234567890123456789012345678901234567890";
        vdig[5] = 128'he33b4ddc9c38f2199c3e7b164fcc0536;
        for (int v = 0; v < 6; v++) begin
            push_str(vmsg[v]);
            do_hash(64'(vmsg[v].len()), vdig[v], ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL kat%0d_done: DONE_OUT not seen within 4000 cycles, required DONE", v);
            end
            total++;
            if (rd_cnt != vmsg[v].len()) begin
                bad++;
                $display("FAIL kat%0d_reads: got %0d reads, required %0d", v, rd_cnt, vmsg[v].len());
            end
            total++;
            if (wr_cnt != 16 || exp_q.size() != 0) begin
                bad++;
                $display("FAIL kat%0d_writes: got %0d writes (%0d pending), required 16", v, wr_cnt, exp_q.size());
            end
            total++;
            if (BUSY_OUT !== 1'b0) begin
                bad++;
                $display("FAIL kat%0d_busy_in_done: BUSY_OUT=%0b, required 0", v, BUSY_OUT);
            end
            release_start();
            total++;
            if (DONE_OUT !== 1'b0) begin
                bad++;
                $display("FAIL kat%0d_done_clear: DONE_OUT=%0b after START low, required 0", v, DONE_OUT);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bp_mode = 1'b1;
        push_str("1234567891234567");
        do_hash(64'd16, 128'h2baa0645e8c33c14022716e6da14b81c, ok);
        total++;
        if (!ok || rd_cnt != 16 || wr_cnt != 16 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL backpressure: done=%0b reads=%0d writes=%0d pending=%0d, required 1/16/16/0",
                     ok, rd_cnt, wr_cnt, exp_q.size());
        end
        release_start();
        bp_mode = 1'b0;
    endtask

    task automatic test_reset_mid_round();
        bit ok;
        push_str("abc");
        in_q.push_back(8'hEE);
        @(posedge CLK);
        #1;
        INPUT_SIZE_IN = 64'd3;
        START_IN = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge CLK);
            if (BUSY_OUT === 1'b1) ok = 1'b1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL start_busy: BUSY_OUT not raised within 20 cycles, required 1");
        end
        repeat (70) @(posedge CLK);
        #1;
        RESET = 1'b1;
        START_IN = 1'b0;
        in_q.delete();
        exp_q.delete();
        #2;
        total++;
        if ({BUSY_OUT, DONE_OUT, INPUT_READ, OUTPUT_WRITE, OUTPUT_BYTE} !== 12'h000) begin
            bad++;
            $display("FAIL abort_outputs: busy=%0b done=%0b rd=%0b wr=%0b byte=%02h, required all 0",
                     BUSY_OUT, DONE_OUT, INPUT_READ, OUTPUT_WRITE, OUTPUT_BYTE);
        end
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        push_str("abc");
        do_hash(64'd3, 128'ha448017aaf21d8525fc10ae87aa6729d, ok);
        total++;
        if (!ok || rd_cnt != 3 || wr_cnt != 16 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL restart_abc: done=%0b reads=%0d writes=%0d pending=%0d, required 1/3/16/0",
                     ok, rd_cnt, wr_cnt, exp_q.size());
        end
        // START stays high: the core must sit in DONE without a second hash.
        repeat (200) @(negedge CLK);
        total++;
        if (wr_cnt != 16 || rd_cnt != 3 || DONE_OUT !== 1'b1 || BUSY_OUT !== 1'b0) begin
            bad++;
            $display("FAIL start_held: writes=%0d reads=%0d done=%0b busy=%0b, required 16/3/1/0",
                     wr_cnt, rd_cnt, DONE_OUT, BUSY_OUT);
        end
        release_start();
    endtask

    initial begin
        test_reset();
        test_known_answers();
        test_backpressure();
        test_reset_mid_round();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
